// File: rtl/alu_chan_mux_if.sv
// Bundle of the N-channel operand-select handshake between operand sources and the ALU input stage.
// A beat moves on channel i when in_valid[i] & in_ready[i], and on the output when out_valid & out_ready.
// A valid is held until accepted, and a ready never depends on its own valid except through the grant.
interface alu_chan_mux_if #(
  parameter int WIDTH  = 64,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic                    mode;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/alu_chan_mux.sv
// Registered N:1 channel selector with explicit-select or round-robin arbitration.
// One output register stage; drain and refill happen on the same edge.
module alu_chan_mux #(
  parameter int WIDTH  = 64,
  parameter int NUM_CH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  alu_chan_mux_if.slave              bus,
  output logic [$clog2(NUM_CH)-1:0]  dbg_rr_ptr_o
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;
  logic             xfer;
  int               rr_dist;
  int               rr_best;

  assign load_en = ~out_valid_q | bus.out_ready;

  // Round-robin: distance 0 is the channel right after rr_ptr, rr_ptr itself is last.
  always_comb begin : grant_logic
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_dist   = 0;
    rr_best   = NUM_CH;
    if (!bus.mode) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((bus.sel == SEL_W'(i)) && bus.in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        rr_dist = (i + NUM_CH - 1 - int'(rr_ptr_q)) % NUM_CH;
        if (bus.in_valid[i] && (rr_dist < rr_best)) begin
          rr_best   = rr_dist;
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin : ready_and_data
    bus.in_ready = '0;
    sel_data     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        bus.in_ready[i] = load_en & grant_vld;
        sel_data        = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = load_en & grant_vld;

  always_comb begin : next_state
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = sel_data;
        out_ch_d   = grant_idx;
        rr_ptr_d   = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign dbg_rr_ptr_o  = rr_ptr_q;
endmodule

// File: tb/tb_alu_chan_mux.sv
// Bench for alu_chan_mux: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_alu_chan_mux;
  localparam int W4 = 64;
  localparam int N4 = 4;
  localparam int S4 = 2;
  localparam int W3 = 16;
  localparam int N3 = 3;
  localparam int S3 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_chan_mux_if #(.WIDTH(W4), .NUM_CH(N4)) bus4 ();
  alu_chan_mux_if #(.WIDTH(W3), .NUM_CH(N3)) bus3 ();
  logic [S4-1:0] dbg4;
  logic [S3-1:0] dbg3;

  alu_chan_mux #(.WIDTH(W4), .NUM_CH(N4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave), .dbg_rr_ptr_o(dbg4));
  alu_chan_mux #(.WIDTH(W3), .NUM_CH(N3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave), .dbg_rr_ptr_o(dbg3));

  int n_checks = 0;
  int n_pass   = 0;
  logic [W4-1:0] d4 [N4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic mode, input logic [S4-1:0] sel,
                        input logic [N4-1:0] valid, input logic ordy);
    bus4.mode      = mode;
    bus4.sel       = sel;
    bus4.in_valid  = valid;
    bus4.out_ready = ordy;
    for (int i = 0; i < N4; i++) bus4.in_data[i*W4 +: W4] = d4[i];
  endtask

  task automatic set_default_data();
    for (int i = 0; i < N4; i++) d4[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
  endtask

  task automatic do_reset();
    drive4(1'b0, '0, '0, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [W4+S4-1:0] exp_q[$];
  int m_ptr;

  function automatic int model_grant(input logic mode, input int sel,
                                     input logic [N4-1:0] v, input int ptr);
    if (!mode) return (sel < N4 && v[sel]) ? sel : -1;
    for (int step = 1; step <= N4; step++) begin
      int c;
      c = (ptr + step) % N4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          mode;
    logic [S4-1:0] sel;
    logic [N4-1:0] valid;
    logic [N4-1:0] exp_rdy;
    logic          exp_ov;
    logic [S4-1:0] exp_ch;
  } vec_t;
  vec_t vecs [8];

  initial begin
    logic [N4-1:0] exp_rdy;
    logic [W4-1:0] held;
    int g;
    logic load, ordy, md;
    logic [S4-1:0] sl;
    logic [N4-1:0] vl;

    vecs[0] = '{1'b0, 2'd2, 4'b0100, 4'b0100, 1'b1, 2'd2};
    vecs[1] = '{1'b0, 2'd1, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vecs[2] = '{1'b1, 2'd0, 4'b1111, 4'b0001, 1'b1, 2'd0};
    vecs[3] = '{1'b1, 2'd2, 4'b1010, 4'b0010, 1'b1, 2'd1};
    vecs[4] = '{1'b1, 2'd0, 4'b1000, 4'b1000, 1'b1, 2'd3};
    vecs[5] = '{1'b0, 2'd3, 4'b1111, 4'b1000, 1'b1, 2'd3};
    vecs[6] = '{1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[7] = '{1'b0, 2'd0, 4'b0001, 4'b0001, 1'b1, 2'd0};

    bus3.mode = 1'b0; bus3.sel = '0; bus3.in_valid = '0; bus3.out_ready = 1'b1;
    for (int i = 0; i < N3; i++) bus3.in_data[i*W3 +: W3] = 16'hA000 | 16'(i);
    set_default_data();
    do_reset();

    // reset state
    check("reset_out_valid", 64'(bus4.out_valid), 64'd0);
    check("reset_out_data", bus4.out_data, 64'd0);
    check("reset_out_ch", 64'(bus4.out_ch), 64'd0);
    check("reset_rr_ptr", 64'(dbg4), 64'd3);
    check("reset_rr_ptr_n3", 64'(dbg3), 64'd2);

    foreach (vecs[k]) begin
      do_reset();
      drive4(vecs[k].mode, vecs[k].sel, vecs[k].valid, 1'b1);
      #1;
      check($sformatf("vec%0d_in_ready", k), 64'(bus4.in_ready), 64'(vecs[k].exp_rdy));
      tick();
      check($sformatf("vec%0d_out_valid", k), 64'(bus4.out_valid), 64'(vecs[k].exp_ov));
      check($sformatf("vec%0d_out_ch", k), 64'(bus4.out_ch), 64'(vecs[k].exp_ch));
      check($sformatf("vec%0d_out_data", k), bus4.out_data,
            vecs[k].exp_ov ? (64'hDEAD_BEEF_0000_0000 | 64'(vecs[k].exp_ch)) : 64'd0);
    end

    // round-robin fairness: all valid, 0,1,2,3,0,1
    do_reset();
    drive4(1'b1, '0, 4'b1111, 1'b1);
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_fair%0d_in_ready", k), 64'(bus4.in_ready), 64'(4'b0001 << (k % 4)));
      tick();
      check($sformatf("rr_fair%0d_out_valid", k), 64'(bus4.out_valid), 64'd1);
      check($sformatf("rr_fair%0d_out_ch", k), 64'(bus4.out_ch), 64'(k % 4));
    end

    // reset mid-burst: outputs clear without an edge
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(bus4.out_valid), 64'd0);
    check("async_rst_out_data", bus4.out_data, 64'd0);
    check("async_rst_out_ch", 64'(bus4.out_ch), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus4.in_ready), 64'b0001);
    tick();
    check("post_rst_out_ch", 64'(bus4.out_ch), 64'd0);
    check("post_rst_out_valid", 64'(bus4.out_valid), 64'd1);

    // backpressure: held output stable while inputs churn
    do_reset();
    drive4(1'b0, 2'd2, 4'b0100, 1'b1);
    tick();
    held = d4[2];
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N4; i++) d4[i] = {$urandom, $urandom};
      drive4(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'b1111, 1'b0);
      #1;
      check($sformatf("bp%0d_in_ready", k), 64'(bus4.in_ready), 64'd0);
      tick();
      check($sformatf("bp%0d_out_data", k), bus4.out_data, held);
      check($sformatf("bp%0d_out_ch", k), 64'(bus4.out_ch), 64'd2);
      check($sformatf("bp%0d_out_valid", k), 64'(bus4.out_valid), 64'd1);
    end
    drive4(1'b1, 2'd0, 4'b1111, 1'b1);
    #1;
    check("bp_release_in_ready", 64'(bus4.in_ready), 64'b1000);
    tick();
    check("bp_release_out_ch", 64'(bus4.out_ch), 64'd3);
    check("bp_release_out_data", bus4.out_data, d4[3]);
    check("bp_release_out_valid", 64'(bus4.out_valid), 64'd1);

    // sparse round-robin from rr_ptr=1, then mode switch to explicit sel=1
    set_default_data();
    do_reset();
    drive4(1'b0, 2'd1, 4'b0010, 1'b1);
    tick();
    check("sparse_seed_rr_ptr", 64'(dbg4), 64'd1);
    drive4(1'b1, 2'd0, 4'b1010, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("sparse%0d_in_ready", k), 64'(bus4.in_ready), (k % 2 == 0) ? 64'b1000 : 64'b0010);
      tick();
      check($sformatf("sparse%0d_out_ch", k), 64'(bus4.out_ch), (k % 2 == 0) ? 64'd3 : 64'd1);
    end
    drive4(1'b0, 2'd1, 4'b1010, 1'b1);
    #1;
    check("sparse_sw_in_ready", 64'(bus4.in_ready), 64'b0010);
    tick();
    check("sparse_sw_out_ch", 64'(bus4.out_ch), 64'd1);
    check("sparse_sw_out_data", bus4.out_data, 64'hDEAD_BEEF_0000_0001);

    // NUM_CH=3: out-of-range select never grants
    bus3.mode = 1'b0; bus3.sel = 2'd3; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
    #1;
    check("n3_sel3_in_ready", 64'(bus3.in_ready), 64'd0);
    tick();
    check("n3_sel3_out_valid", 64'(bus3.out_valid), 64'd0);
    bus3.sel = 2'd2;
    #1;
    check("n3_sel2_in_ready", 64'(bus3.in_ready), 64'b100);
    tick();
    check("n3_sel2_out_ch", 64'(bus3.out_ch), 64'd2);
    check("n3_sel2_out_data", 64'(bus3.out_data), 64'hA002);

    // randomized traffic against the reference model
    do_reset();
    exp_q.delete();
    m_ptr = N4 - 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N4; i++) d4[i] = {$urandom, $urandom};
      md   = ($urandom_range(0, 2) != 0);
      sl   = 2'($urandom_range(0, 3));
      vl   = 4'($urandom_range(0, 15));
      ordy = ($urandom_range(0, 3) != 0);
      drive4(md, sl, vl, ordy);
      #1;
      load = (exp_q.size() == 0) || ordy;
      g = model_grant(md, int'(sl), vl, m_ptr);
      exp_rdy = (load && g >= 0) ? 4'(4'b0001 << g) : 4'b0000;
      check("rand_in_ready", 64'(bus4.in_ready), 64'(exp_rdy));
      tick();
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (load && g >= 0) begin
        exp_q.push_back({S4'(g), d4[g]});
        m_ptr = g;
      end
      check("rand_out_valid", 64'(bus4.out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("rand_out_ch", 64'(bus4.out_ch), 64'(exp_q[0][W4 +: S4]));
        check("rand_out_data", bus4.out_data, exp_q[0][W4-1:0]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_chan_mux.md
# alu_chan_mux

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking and a selectable arbitration mode (explicit select or round-robin). It generalises the ALU's combinational 2:1/4:1 operand muxes into a pipelined channel selector. It sits between the operand sources (register file ports, forwarding paths, immediates) and the 64-bit ALU input stage. Throughput is one transfer per cycle with a single output register stage.

## Interface
- WIDTH, 64, data width per channel (≥1)
- NUM_CH, 4, number of input channels (≥2)
- SEL_W, $clog2(NUM_CH), select/channel-index width (derived; do not override)

- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_CH  per-channel valid
- in_ready  output  NUM_CH  per-channel ready (combinational)
- sel  input  SEL_W  channel index used when mode=0
- mode  input  1  0 = explicit select, 1 = round-robin
- out_data  output  WIDTH  registered selected data
- out_valid  output  1  registered valid
- out_ch  output  SEL_W  index of the channel that supplied out_data
- out_ready  input  1  downstream ready

## Operation
- Load enable: load_en = ~out_valid | out_ready (stage empty or draining this cycle).
- Grant (combinational, at most one channel):
  - mode=0: grant = sel when sel < NUM_CH and in_valid[sel]; otherwise no grant. sel ≥ NUM_CH never grants.
  - mode=1: search channels rr_ptr+1, rr_ptr+2, … wrapping modulo NUM_CH; first with in_valid set wins. The channel at rr_ptr itself is checked last.
- in_ready[i] = load_en & (grant == i) & grant exists. All other in_ready bits are 0. No combinational path from in_valid[j] to in_ready[i] in mode=0 other than through grant.
- Transfer on channel i when in_valid[i] & in_ready[i].
- On a clock edge with load_en:
  - With a transfer: out_data ← channel data, out_ch ← i, out_valid ← 1.
  - Without a transfer: out_valid ← 0; out_data and out_ch hold.
- Without load_en (out_valid=1, out_ready=0): all outputs hold and are stable.
- rr_ptr ← i on every transfer in either mode, so switching to mode=1 continues fairly from the last served channel. It holds otherwise.
- A mode or sel change is sampled combinationally in the same cycle. It never disturbs the occupied output register.
- Starvation bound in mode=1: a continuously valid channel is granted within NUM_CH transfers.

## Timing
- Reset (asynchronous assert, synchronous-edge release): out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1 (channel 0 has first priority). in_ready follows combinationally (load_en=1 because out_valid=0).
- Latency: one cycle from input transfer to out_valid/out_data.
- Throughput: one transfer per cycle while out_ready=1. A back-to-back drain and fill occurs in the same edge.
- Reset mid-operation: the held output is discarded and out_valid drops immediately, without waiting for clk. No transfer is reported on the reset cycle.
- Simultaneous events: multiple valids resolve to exactly one grant. A drain and a new transfer on the same edge is legal and required.

## Test plan
- Reset: assert rst mid-burst with out_valid=1 → out_valid=0, out_data=0, out_ch=0 without a clock edge. The first mode=1 grant after release goes to ch0 when all channels are valid.
- Explicit select: mode=0, sel=2, ch2 data 0xDEAD_BEEF_0000_0002 valid, out_ready=1 → next cycle out_valid=1, out_data=0xDEAD_BEEF_0000_0002, out_ch=2. in_ready=4'b0100 during the transfer cycle.
- Invalid select: NUM_CH=3, sel=3, all channels valid → in_ready all 0, out_valid=0.
- Round-robin fairness: mode=1, all 4 channels valid continuously, out_ready=1 → out_ch sequence 0,1,2,3,0,1 on consecutive cycles, one transfer per cycle.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles, inputs changing → out_data/out_ch stable and in_ready all 0. Raising out_ready gives a drain and new load on the same edge.
- Sparse round-robin: mode=1, only ch1 and ch3 valid, starting with rr_ptr=1 → grants 3,1,3,1. A mode switch to 0 with sel=1 then grants ch1 on the next cycle.
